// File: rtl/conv_channel_accumulator.sv
// Multi-channel windowed convolution accumulator: N-tap MAC per beat, accumulated over a channel group,
// then bias, rounding, saturation/wrap and ReLU, returned over a valid/ready handshake.
module conv_channel_accumulator #(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned INT_WIDTH    = 12,
  parameter int unsigned FRAC_WIDTH   = 20,
  parameter int unsigned MAX_CHANNELS = 16,
  localparam int unsigned N  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned W  = INT_WIDTH + FRAC_WIDTH,
  localparam int unsigned CW = $clog2(MAX_CHANNELS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   cfg_channels,
  input  logic            cfg_round,
  input  logic            cfg_saturate,
  input  logic            cfg_relu,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  din,
  input  logic [N*W-1:0]  weights,
  input  logic [W-1:0]    bias,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    dout,
  output logic            out_sat
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = PW + $clog2(N);
  localparam int unsigned AW = SW + $clog2(MAX_CHANNELS) + 1;

  localparam logic signed [AW-1:0] sat_max = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] sat_min = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] chans_q, chans_d;
  logic round_q, round_d, satur_q, satur_d, relu_q, relu_d;
  logic signed [W-1:0] bias_q, bias_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] dout_q, dout_d;
  logic out_sat_q, out_sat_d;

  logic signed [PW-1:0] prod_q [N];
  logic v0_q, first0_q, last0_q;
  logic signed [SW-1:0] sum_c, sum_q;
  logic v1_q, first1_q, last1_q;
  logic signed [AW-1:0] acc_q;

  logic accept, first_beat, last_beat;
  logic [CW-1:0] chans_eff, grp_chans;
  logic signed [AW-1:0] rnd_c, sh_c;
  logic [W-1:0] res_c;
  logic sat_c;

  assign accept     = in_valid && in_ready_q;
  assign first_beat = accept && (count_q == '0);
  assign chans_eff  = (cfg_channels == '0) ? CW'(1) : cfg_channels;
  assign grp_chans  = first_beat ? chans_eff : chans_q;
  assign last_beat  = accept && (CW'(count_q + CW'(1)) == grp_chans);

  // Product stage, window-sum stage and accumulator stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) prod_q[i] <= '0;
      v0_q     <= 1'b0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
      sum_q    <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N; i++)
          prod_q[i] <= PW'($signed(din[i*W +: W])) * PW'($signed(weights[i*W +: W]));
      end
      v0_q     <= accept;
      first0_q <= first_beat;
      last0_q  <= last_beat;
      if (v0_q) sum_q <= sum_c;
      v1_q     <= v0_q;
      first1_q <= first0_q;
      last1_q  <= last0_q;
      if (v1_q) acc_q <= first1_q ? AW'(sum_q) : acc_q + AW'(sum_q);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) sum_c = sum_c + SW'(prod_q[i]);
  end

  // Finalise: bias align, optional round-half-up, shift, then clamp or wrap, then ReLU
  always_comb begin
    rnd_c = round_q ? (AW'(1) <<< (FRAC_WIDTH - 1)) : '0;
    sh_c  = (acc_q + (AW'(bias_q) <<< FRAC_WIDTH) + rnd_c) >>> FRAC_WIDTH;
    sat_c = 1'b0;
    res_c = sh_c[W-1:0];
    if (satur_q && (sh_c > sat_max)) begin
      res_c = sat_max[W-1:0];
      sat_c = 1'b1;
    end else if (satur_q && (sh_c < sat_min)) begin
      res_c = sat_min[W-1:0];
      sat_c = 1'b1;
    end
    if (relu_q && res_c[W-1]) res_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACCEPT;
      count_q     <= '0;
      chans_q     <= '0;
      round_q     <= 1'b0;
      satur_q     <= 1'b0;
      relu_q      <= 1'b0;
      bias_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      chans_q     <= chans_d;
      round_q     <= round_d;
      satur_q     <= satur_d;
      relu_q      <= relu_d;
      bias_q      <= bias_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_sat_q   <= out_sat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    chans_d     = chans_q;
    round_d     = round_q;
    satur_d     = satur_q;
    relu_d      = relu_q;
    bias_d      = bias_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_ACCEPT: begin
        in_ready_d = 1'b1;
        if (accept) begin
          count_d = CW'(count_q + CW'(1));
          if (first_beat) begin
            chans_d = chans_eff;
            round_d = cfg_round;
            satur_d = cfg_saturate;
            relu_d  = cfg_relu;
            bias_d  = bias;
          end
          if (last_beat) begin
            in_ready_d = 1'b0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        in_ready_d = 1'b0;
        // last beat's sum enters the accumulator on this edge
        if (v1_q && last1_q) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        in_ready_d = 1'b0;
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          dout_d      = res_c;
          out_sat_d   = sat_c;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          in_ready_d  = 1'b1;
          state_d     = ST_ACCEPT;
        end
      end
      default: begin
        state_d    = ST_ACCEPT;
        in_ready_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_sat   = out_sat_q;

endmodule
